// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the status flag producer: op-class encodings and
// the {Z, C, V, N} bit positions used by the ID-stage condition checker.
package status_pkg;

    localparam logic [2:0] OP_LOGIC = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_ADC   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_SBC   = 3'd4;
    localparam logic [2:0] OP_RSB   = 3'd5;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef logic [3:0] flags_t;

    function automatic flags_t pack_flags(input logic z, input logic c,
                                          input logic v, input logic n);
        flags_t f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        return f;
    endfunction

endpackage

// File: rtl/status_flag_unit_if.sv
// EXE-stage flag-update bus plus pipeline control and the status outputs.
// master drives the EXE side; slave is the status_flag_unit.
interface status_flag_unit_if #(
    parameter int DATA_W = 32
);
    logic              exe_valid;
    logic              exe_s_bit;
    logic [2:0]        exe_op_class;
    logic [DATA_W-1:0] exe_op_a;
    logic [DATA_W-1:0] exe_op_b;
    logic [DATA_W-1:0] exe_result;
    logic              exe_carry_out;
    logic              exe_shift_carry;
    logic              freeze;
    logic              flush;
    logic              save_req;
    logic              restore_req;
    logic [3:0]        status_flags;
    logic [3:0]        status_flags_fwd;
    logic              shadow_valid;
    logic              restore_err;

    modport master (
        output exe_valid, exe_s_bit, exe_op_class, exe_op_a, exe_op_b,
               exe_result, exe_carry_out, exe_shift_carry,
               freeze, flush, save_req, restore_req,
        input  status_flags, status_flags_fwd, shadow_valid, restore_err
    );

    modport slave (
        input  exe_valid, exe_s_bit, exe_op_class, exe_op_a, exe_op_b,
               exe_result, exe_carry_out, exe_shift_carry,
               freeze, flush, save_req, restore_req,
        output status_flags, status_flags_fwd, shadow_valid, restore_err
    );

endinterface

// File: rtl/status_flag_unit_flag_calc.sv
// Combinational N/Z/C/V derivation from the EXE-stage ALU operands and result.
module flag_calc
    import status_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op_class,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] result,
    input  logic              carry_out,
    input  logic              shift_carry,
    input  logic              v_cur,
    output flags_t            flags
);

    logic a_msb;
    logic b_msb;
    logic r_msb;
    logic z;
    logic c;
    logic v;

    assign a_msb = op_a[DATA_W-1];
    assign b_msb = op_b[DATA_W-1];
    assign r_msb = result[DATA_W-1];
    assign z     = (result == '0);

    always_comb begin
        c = shift_carry;
        v = v_cur;
        case (op_class)
            OP_ADD, OP_ADC: begin
                c = carry_out;
                v = (a_msb == b_msb) && (r_msb != a_msb);
            end
            OP_SUB, OP_SBC: begin
                c = carry_out;
                v = (a_msb != b_msb) && (r_msb != a_msb);
            end
            OP_RSB: begin
                c = carry_out;
                v = (b_msb != a_msb) && (r_msb != b_msb);
            end
            // Logic ops and the unused codes keep V and take the shifter carry.
            default: begin
                c = shift_carry;
                v = v_cur;
            end
        endcase
    end

    assign flags = pack_flags(z, c, v, r_msb);

endmodule

// File: rtl/status_flag_unit.sv
// Architectural status register with same-cycle bypass and a one-entry
// shadow for flag save/restore across exception entry and return.
module status_flag_unit
    import status_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    status_flag_unit_if.slave bus
);

    flags_t flags_q;
    flags_t flags_d;
    flags_t shadow_q;
    flags_t shadow_d;
    logic   shadow_valid_q;
    logic   shadow_valid_d;
    logic   restore_err_q;
    logic   restore_err_d;
    flags_t calc_flags;
    logic   upd;
    logic   restore_ok;

    flag_calc #(
        .DATA_W (DATA_W)
    ) u_flag_calc (
        .op_class    (bus.exe_op_class),
        .op_a        (bus.exe_op_a),
        .op_b        (bus.exe_op_b),
        .result      (bus.exe_result),
        .carry_out   (bus.exe_carry_out),
        .shift_carry (bus.exe_shift_carry),
        .v_cur       (flags_q[FLAG_V]),
        .flags       (calc_flags)
    );

    assign upd        = bus.exe_valid & bus.exe_s_bit & ~bus.flush & ~bus.freeze;
    assign restore_ok = bus.restore_req & shadow_valid_q;

    always_comb begin
        flags_d        = flags_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        restore_err_d  = 1'b0;
        if (!bus.freeze) begin
            if (restore_ok) begin
                flags_d        = shadow_q;
                shadow_valid_d = 1'b0;
            end else if (upd) begin
                flags_d = calc_flags;
            end
            // Save captures the pre-update flags and wins over a same-cycle restore.
            if (bus.save_req) begin
                shadow_d       = flags_q;
                shadow_valid_d = 1'b1;
            end
            restore_err_d = bus.restore_req & ~shadow_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q        <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            restore_err_q  <= 1'b0;
        end else begin
            flags_q        <= flags_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            restore_err_q  <= restore_err_d;
        end
    end

    assign bus.status_flags     = flags_q;
    assign bus.status_flags_fwd = flags_d;
    assign bus.shadow_valid     = shadow_valid_q;
    assign bus.restore_err      = restore_err_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: the driver queues hand-computed
// expectations per cycle, the monitor pops and compares them.
module tb_status_flag_unit;
    import status_pkg::*;

    localparam logic [5:0] C_IDLE = 6'b000000;
    localparam logic [5:0] C_UPD  = 6'b110000;
    localparam logic [5:0] C_NOS  = 6'b100000;
    localparam logic [5:0] C_FL   = 6'b001000;
    localparam logic [5:0] C_FR   = 6'b000100;
    localparam logic [5:0] C_SV   = 6'b000010;
    localparam logic [5:0] C_RS   = 6'b000001;

    typedef struct {
        string      name;
        logic [3:0] flags;
        logic [3:0] fwd;
        logic       sv;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t q[$];
    event chk_now;

    status_flag_unit_if #(.DATA_W(32)) bus ();

    status_flag_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r,
                          input logic co, input logic sc, input logic [5:0] ctl);
        bus.exe_op_class    = op;
        bus.exe_op_a        = a;
        bus.exe_op_b        = b;
        bus.exe_result      = r;
        bus.exe_carry_out   = co;
        bus.exe_shift_carry = sc;
        bus.exe_valid       = ctl[5];
        bus.exe_s_bit       = ctl[4];
        bus.flush           = ctl[3];
        bus.freeze          = ctl[2];
        bus.save_req        = ctl[1];
        bus.restore_req     = ctl[0];
    endtask

    task automatic push(input string name, input logic [3:0] ef,
                        input logic [3:0] efwd, input logic esv, input logic eerr);
        exp_t e;
        e.name  = name;
        e.flags = ef;
        e.fwd   = efwd;
        e.sv    = esv;
        e.err   = eerr;
        q.push_back(e);
    endtask

    // One pipeline cycle: inputs after the edge, expectation observed at negedge.
    task automatic cyc(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic co, input logic sc, input logic [5:0] ctl,
                       input logic [3:0] ef, input logic [3:0] efwd,
                       input logic esv, input logic eerr);
        @(posedge clk);
        #1;
        set_in(op, a, b, r, co, sc, ctl);
        push(name, ef, efwd, esv, eerr);
    endtask

    task automatic idle(input string name, input logic [3:0] ef,
                        input logic esv, input logic eerr);
        cyc(name, OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_IDLE, ef, ef, esv, eerr);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_now);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (bus.status_flags !== e.flags) begin
                    bad++;
                    $display("FAIL %s.flags got=%b want=%b", e.name, bus.status_flags, e.flags);
                end
                total++;
                if (bus.status_flags_fwd !== e.fwd) begin
                    bad++;
                    $display("FAIL %s.fwd got=%b want=%b", e.name, bus.status_flags_fwd, e.fwd);
                end
                total++;
                if (bus.shadow_valid !== e.sv) begin
                    bad++;
                    $display("FAIL %s.shadow_valid got=%b want=%b", e.name, bus.shadow_valid, e.sv);
                end
                total++;
                if (bus.restore_err !== e.err) begin
                    bad++;
                    $display("FAIL %s.restore_err got=%b want=%b", e.name, bus.restore_err, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_in(OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_IDLE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        idle("reset", 4'b0000, 1'b0, 1'b0);
        cyc("add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, C_UPD,        4'b0000, 4'b0011, 1'b0, 1'b0);
        cyc("sub_eq",   OP_SUB, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, C_UPD,                      4'b0011, 4'b1100, 1'b0, 1'b0);
        cyc("flush",    OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, C_UPD | C_FL, 4'b1100, 4'b1100, 1'b0, 1'b0);
        cyc("no_s",     OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, C_NOS,        4'b1100, 4'b1100, 1'b0, 1'b0);
        cyc("sub_v",    OP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b0, C_UPD,        4'b1100, 4'b0110, 1'b0, 1'b0);
        cyc("logic_v",  OP_LOGIC, 32'h0, 32'h0, 32'h10, 1'b0, 1'b0, C_UPD,                   4'b0110, 4'b0010, 1'b0, 1'b0);
        cyc("logic_z",  OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, C_UPD,                    4'b0010, 4'b1110, 1'b0, 1'b0);
        cyc("rsb_v",    OP_RSB, 32'h1, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, C_UPD,        4'b1110, 4'b0110, 1'b0, 1'b0);
        cyc("adc",      OP_ADC, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, C_UPD,                      4'b0110, 4'b0000, 1'b0, 1'b0);
        cyc("op7",      3'd7, 32'h0, 32'h0, 32'h80000000, 1'b0, 1'b1, C_UPD,                 4'b0000, 4'b0101, 1'b0, 1'b0);
        cyc("set_z",    OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_UPD,                    4'b0101, 4'b1000, 1'b0, 1'b0);
        cyc("save_upd", OP_ADD, 32'h80000000, 32'h1, 32'h80000001, 1'b0, 1'b0, C_UPD | C_SV, 4'b1000, 4'b0001, 1'b0, 1'b0);
        cyc("rest_upd", OP_ADD, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, C_UPD | C_RS,               4'b0001, 4'b1000, 1'b1, 1'b0);
        idle("after_rest", 4'b1000, 1'b0, 1'b0);
        cyc("rest_empty", OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_RS,                   4'b1000, 4'b1000, 1'b0, 1'b0);
        idle("err_pulse", 4'b1000, 1'b0, 1'b1);
        idle("err_clear", 4'b1000, 1'b0, 1'b0);
        cyc("frz_save", OP_ADD, 32'h80000000, 32'h1, 32'h80000001, 1'b0, 1'b0, C_UPD | C_FR | C_SV, 4'b1000, 4'b1000, 1'b0, 1'b0);
        cyc("frz_rest", OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_FR | C_RS,              4'b1000, 4'b1000, 1'b0, 1'b0);
        idle("frz_done", 4'b1000, 1'b0, 1'b0);
        cyc("save",     OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_SV,                     4'b1000, 4'b1000, 1'b0, 1'b0);
        cyc("frz_rest2", OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_FR | C_RS,             4'b1000, 4'b1000, 1'b1, 1'b0);
        idle("still_saved", 4'b1000, 1'b1, 1'b0);
        cyc("upd_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, C_UPD,        4'b1000, 4'b0011, 1'b1, 1'b0);
        cyc("save_rest", OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_SV | C_RS,             4'b0011, 4'b1000, 1'b1, 1'b0);
        idle("after_sr", 4'b1000, 1'b1, 1'b0);
        cyc("restore2", OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_RS,                     4'b1000, 4'b0011, 1'b1, 1'b0);
        idle("after_r2", 4'b0011, 1'b0, 1'b0);
        cyc("save3",    OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_SV,                     4'b0011, 4'b0011, 1'b0, 1'b0);
        idle("saved3", 4'b0011, 1'b1, 1'b0);

        // Mid-cycle async reset: state must clear before any clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push("async_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
        ->chk_now;
        @(negedge clk);
        rst_n = 1'b1;

        idle("post_rst", 4'b0000, 1'b0, 1'b0);
        cyc("rest_post", OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, C_RS,                    4'b0000, 4'b0000, 1'b0, 1'b0);
        idle("err_post", 4'b0000, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
